// File: rtl/imm_inst_encoder_if.sv
// Request/response bus of the immediate instruction encoder.
// The slave side is the encoder; the master side is the injector or testbench.
interface imm_inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [63:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic        out_last;

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err, out_last
    );

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err, out_last
    );
endinterface

// File: rtl/imm_inst_encoder.sv
// RV64 instruction encoder: packs fields and a range-checked immediate into a
// 32-bit word, expanding LI into ADDI or LUI+ADDIW, with a registered output.
module imm_inst_encoder (
    input  logic               clk,
    input  logic               rst,
    imm_inst_encoder_if.slave  bus
);
    localparam int unsigned XLEN = 64;

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_LI = 3'd6;

    localparam logic [6:0]  OP_IMM   = 7'b0010011;
    localparam logic [6:0]  OP_IMM_W = 7'b0011011;
    localparam logic [6:0]  OP_LUI   = 7'b0110111;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_LI_LO = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        out_err_q, out_err_d;
    logic        out_last_q, out_last_d;
    logic [4:0]  rd_q, rd_d;
    logic [11:0] lo_q, lo_d;

    logic [XLEN-1:0] imm;
    logic [31:0]     enc_inst;
    logic            enc_err;
    logic            enc_two;
    logic [19:0]     li_hi;
    logic            is_shift;
    logic            in_ready;
    logic            accept;

    // True when v equals the sign extension of its low (b+1) bits.
    function automatic logic sext_ok(input logic [XLEN-1:0] v, input int unsigned b);
        logic [XLEN-1:0] s;
        s = $signed(v) >>> b;
        return (s == '0) || (s == '1);
    endfunction

    assign imm = bus.in_imm;

    // (imm + 0x800)[31:12]: the only carry into bit 12 comes from imm[11].
    assign li_hi = imm[31:12] + {19'd0, imm[11]};

    assign is_shift = ((bus.in_opcode == OP_IMM) || (bus.in_opcode == OP_IMM_W)) &&
                      ((bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101));

    always_comb begin
        enc_inst = '0;
        enc_err  = 1'b0;
        enc_two  = 1'b0;
        case (bus.in_fmt)
            FMT_R: begin
                enc_inst = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            bus.in_rd, bus.in_opcode};
            end
            FMT_I: begin
                if (is_shift) begin
                    enc_err  = (bus.in_opcode == OP_IMM) ? (imm[63:6] != '0)
                                                         : (imm[63:5] != '0);
                    enc_inst = {bus.in_funct7[6:1], imm[5:0], bus.in_rs1, bus.in_funct3,
                                bus.in_rd, bus.in_opcode};
                end else begin
                    enc_err  = !sext_ok(imm, 11);
                    enc_inst = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
                end
            end
            FMT_S: begin
                enc_err  = !sext_ok(imm, 11);
                enc_inst = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            imm[4:0], bus.in_opcode};
            end
            FMT_B: begin
                enc_err  = !sext_ok(imm, 12) || imm[0];
                enc_inst = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            imm[4:1], imm[11], bus.in_opcode};
            end
            FMT_U: begin
                enc_err  = !sext_ok(imm, 31) || (imm[11:0] != '0);
                enc_inst = {imm[31:12], bus.in_rd, bus.in_opcode};
            end
            FMT_J: begin
                enc_err  = !sext_ok(imm, 20) || imm[0];
                enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
            end
            FMT_LI: begin
                enc_err = !sext_ok(imm, 31);
                if (li_hi == '0) begin
                    enc_inst = {imm[11:0], 5'd0, 3'b000, bus.in_rd, OP_IMM};
                end else begin
                    enc_inst = {li_hi, bus.in_rd, OP_LUI};
                    enc_two  = 1'b1;
                end
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) begin
            enc_inst = NOP;
            enc_two  = 1'b0;
        end
    end

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_err_d   = out_err_q;
        out_last_d  = out_last_q;
        rd_d        = rd_q;
        lo_d        = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_inst_d  = enc_inst;
                    out_err_d   = enc_err;
                    out_last_d  = !enc_two;
                    if (enc_two) begin
                        state_d = S_LI_LO;
                        rd_d    = bus.in_rd;
                        lo_d    = imm[11:0];
                    end
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            S_LI_LO: begin
                // LUI beat is always valid here; swap in ADDIW once it is taken.
                if (bus.out_ready) begin
                    out_inst_d = {lo_q, rd_q, 3'b000, rd_q, OP_IMM_W};
                    out_err_d  = 1'b0;
                    out_last_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_err_q   <= 1'b0;
            out_last_q  <= 1'b0;
            rd_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_err_q   <= out_err_d;
            out_last_q  <= out_last_d;
            rd_q        <= rd_d;
            lo_q        <= lo_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_last  = out_last_q;
endmodule
